// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types and width helpers for the multi-alarm clock.
//               Optional feature macro: MULTI_ALARM_SNOOZE_EN (see alarm_slot).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  // Width of every binary time field (sec/min/hrs/day)
  localparam int TIME_W = 7;

  // Per-alarm ring state; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ALARM_IDLE   = 2'd0,
    ALARM_RING   = 2'd1,
    ALARM_SNOOZE = 2'd2
  } alarm_state_t;

  // Registered time of day
  typedef struct packed {
    logic [TIME_W-1:0] sec;
    logic [TIME_W-1:0] min;
    logic [TIME_W-1:0] hrs;
    logic [TIME_W-1:0] day;
  } time_t;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_alarm_clock_if
// Description : User-control and display bundle of the multi-alarm clock.
//               master = control panel / display side, slave = clock core.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_alarm_clock_if #(
  parameter int NA = 4,
  parameter int ND = 7
);
  localparam int SEL_W  = clock_pkg::width_of(NA);
  localparam int DAY_W  = clock_pkg::width_of(ND);
  localparam int DDAY_W = clock_pkg::width_of(ND + 1);

  // Set-mode levels and user strobes
  logic              Timeset;
  logic              Alarmset;
  logic              Minadv;
  logic              Hrsadv;
  logic              Dayadv;
  logic [SEL_W-1:0]  Sel;
  logic              Armtog;
  logic              Snooze;
  logic              Stop;

  // Time, display and alarm status
  logic [6:0]        TSec;
  logic [6:0]        TMin;
  logic [6:0]        THrs;
  logic [DAY_W-1:0]  TDay;
  logic [6:0]        DMin;
  logic [6:0]        DHrs;
  logic [DDAY_W-1:0] DDay;
  logic [NA-1:0]     Armed;
  logic [NA-1:0]     Ringing;
  logic              Buzz;

  modport master (
    output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Sel, Armtog, Snooze, Stop,
    input  TSec, TMin, THrs, TDay, DMin, DHrs, DDay, Armed, Ringing, Buzz
  );

  modport slave (
    input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Sel, Armtog, Snooze, Stop,
    output TSec, TMin, THrs, TDay, DMin, DHrs, DDay, Armed, Ringing, Buzz
  );

endinterface
`default_nettype wire

// File: rtl/alarm_slot.sv
`default_nettype none
// ============================================================================
// Module      : alarm_slot
// Description : One alarm: hour/minute/day fields, armed flag, match
//               comparator, IDLE/RING/SNOOZE state machine, ring and snooze
//               counters. SNOOZE state and its counter exist only when
//               MULTI_ALARM_SNOOZE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_slot
  import clock_pkg::*;
#(
  parameter int NS   = 60,
  parameter int NH   = 24,
  parameter int ND   = 7,
  parameter int RING = 60
`ifdef MULTI_ALARM_SNOOZE_EN
  ,
  parameter int SNZ  = 9
`endif
) (
  input  wire logic                                i_clk,
  input  wire logic                                i_rst_n,
  input  wire logic                                i_set_en,
  input  wire logic                                i_min_adv,
  input  wire logic                                i_hrs_adv,
  input  wire logic                                i_day_adv,
  input  wire logic                                i_arm_tog,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  wire logic                                i_snooze,
`endif
  input  wire logic                                i_stop,
  input  wire logic                                i_timeset,
  input  wire time_t                               i_now,
  output      logic                                o_armed,
  output      logic                                o_ringing,
  output      logic [TIME_W-1:0]                   o_amin,
  output      logic [TIME_W-1:0]                   o_ahrs,
  output      logic [width_of(ND+1)-1:0]           o_aday
);

  localparam int DDAY_W = width_of(ND + 1);
  localparam int RING_W = width_of(RING);

  localparam logic [TIME_W-1:0] c_min_max   = TIME_W'(NS - 1);
  localparam logic [TIME_W-1:0] c_hrs_max   = TIME_W'(NH - 1);
  localparam logic [DDAY_W-1:0] c_every_day = DDAY_W'(ND);
  localparam logic [RING_W-1:0] c_ring_load = RING_W'(RING - 1);

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam int SNZ_W = width_of(SNZ * 60);
  localparam logic [SNZ_W-1:0] c_snz_load = SNZ_W'(SNZ * 60 - 1);
  logic [SNZ_W-1:0] r_snz_cnt;
  logic [SNZ_W-1:0] w_snz_nxt;
`endif

  logic [TIME_W-1:0] r_amin;
  logic [TIME_W-1:0] r_ahrs;
  logic [DDAY_W-1:0] r_aday;
  logic              r_armed;
  alarm_state_t      r_state;
  alarm_state_t      w_state_nxt;
  logic [RING_W-1:0] r_ring_cnt;
  logic [RING_W-1:0] w_ring_nxt;
  logic              w_match;
  logic              w_disarm;

  // Armtog clears the flag this edge when currently armed
  assign w_disarm = i_arm_tog && r_armed;

  assign w_match = r_armed && !i_timeset && (i_now.sec == '0) &&
                   (i_now.min == r_amin) && (i_now.hrs == r_ahrs) &&
                   ((r_aday == c_every_day) || (TIME_W'(r_aday) == i_now.day));

  // Alarm fields advance only while this slot is selected in alarm-set mode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_amin <= '0;
      r_ahrs <= '0;
      r_aday <= '0;
    end else if (i_set_en) begin
      if (i_min_adv) r_amin <= (r_amin == c_min_max)   ? '0 : r_amin + TIME_W'(1);
      if (i_hrs_adv) r_ahrs <= (r_ahrs == c_hrs_max)   ? '0 : r_ahrs + TIME_W'(1);
      if (i_day_adv) r_aday <= (r_aday == c_every_day) ? '0 : r_aday + DDAY_W'(1);
    end
  end

  // Armed flag toggles once per sampled Armtog strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_armed <= 1'b0;
    else if (i_arm_tog) r_armed <= ~r_armed;
  end

  // Next state and counter values; priority Stop > disarm > Snooze > timeout > Match
  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
`ifdef MULTI_ALARM_SNOOZE_EN
    w_snz_nxt   = r_snz_cnt;
`endif
    case (r_state)
      ALARM_IDLE: begin
        if (w_match && !w_disarm) begin
          w_state_nxt = ALARM_RING;
          w_ring_nxt  = c_ring_load;
        end
      end
      ALARM_RING: begin
        w_ring_nxt = r_ring_cnt - RING_W'(1);
        if (i_stop || w_disarm) begin
          w_state_nxt = ALARM_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
        end else if (i_snooze) begin
          w_state_nxt = ALARM_SNOOZE;
          w_snz_nxt   = c_snz_load;
`endif
        end else if (r_ring_cnt == '0) begin
          w_state_nxt = ALARM_IDLE;
        end
      end
`ifdef MULTI_ALARM_SNOOZE_EN
      ALARM_SNOOZE: begin
        w_snz_nxt = r_snz_cnt - SNZ_W'(1);
        if (i_stop || w_disarm) begin
          w_state_nxt = ALARM_IDLE;
        end else if ((r_snz_cnt == '0) || w_match) begin
          w_state_nxt = ALARM_RING;
          w_ring_nxt  = c_ring_load;
        end
      end
`endif
      default: w_state_nxt = ALARM_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ALARM_IDLE;
      r_ring_cnt <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      r_snz_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_nxt;
`ifdef MULTI_ALARM_SNOOZE_EN
      r_snz_cnt  <= w_snz_nxt;
`endif
    end
  end

  assign o_armed   = r_armed;
  assign o_ringing = (r_state == ALARM_RING);
  assign o_amin    = r_amin;
  assign o_ahrs    = r_ahrs;
  assign o_aday    = r_aday;

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module      : multi_alarm_clock
// Description : Time-of-day chain (sec/min/hrs/day) with NA armable alarms,
//               display mux and buzzer OR. Build macro MULTI_ALARM_SNOOZE_EN
//               enables the snooze state in every alarm slot.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_alarm_clock #(
  parameter int NS   = 60,
  parameter int NH   = 24,
  parameter int ND   = 7,
  parameter int NA   = 4,
  parameter int SNZ  = 9,
  parameter int RING = 60
) (
  input wire logic             Pulse,
  input wire logic             Reset,
  multi_alarm_clock_if.slave   bus
);
  import clock_pkg::*;

  localparam int SEL_W  = width_of(NA);
  localparam int DAY_W  = width_of(ND);
  localparam int DDAY_W = width_of(ND + 1);

  localparam logic [TIME_W-1:0] c_sec_max = TIME_W'(NS - 1);
  localparam logic [TIME_W-1:0] c_min_max = TIME_W'(NS - 1);
  localparam logic [TIME_W-1:0] c_hrs_max = TIME_W'(NH - 1);
  localparam logic [TIME_W-1:0] c_day_max = TIME_W'(ND - 1);

  time_t             r_time;
  logic              w_run;
  logic              w_sec_max;
  logic              w_min_max;
  logic              w_hrs_max;
  logic              w_day_max;
  logic              w_min_inc;
  logic              w_hrs_inc;
  logic              w_day_inc;
  logic              w_alarm_set;

  logic [TIME_W-1:0] w_amin [NA];
  logic [TIME_W-1:0] w_ahrs [NA];
  logic [DDAY_W-1:0] w_aday [NA];
  logic [NA-1:0]     w_armed;
  logic [NA-1:0]     w_ringing;

  assign w_run     = !bus.Timeset;
  assign w_sec_max = (r_time.sec == c_sec_max);
  assign w_min_max = (r_time.min == c_min_max);
  assign w_hrs_max = (r_time.hrs == c_hrs_max);
  assign w_day_max = (r_time.day == c_day_max);

  // Carries only ripple from a running clock; manual advance never carries
  assign w_min_inc = (w_run && w_sec_max) || (bus.Timeset && bus.Minadv);
  assign w_hrs_inc = (w_run && w_sec_max && w_min_max) || (bus.Timeset && bus.Hrsadv);
  assign w_day_inc = (w_run && w_sec_max && w_min_max && w_hrs_max) ||
                     (bus.Timeset && bus.Dayadv);

  // Time-of-day counters, each wrapping at its modulus
  always_ff @(posedge Pulse or negedge Reset) begin
    if (!Reset) begin
      r_time <= '0;
    end else begin
      if (w_run)     r_time.sec <= w_sec_max ? '0 : r_time.sec + TIME_W'(1);
      if (w_min_inc) r_time.min <= w_min_max ? '0 : r_time.min + TIME_W'(1);
      if (w_hrs_inc) r_time.hrs <= w_hrs_max ? '0 : r_time.hrs + TIME_W'(1);
      if (w_day_inc) r_time.day <= w_day_max ? '0 : r_time.day + TIME_W'(1);
    end
  end

  // Alarm-set mode is overridden by time-set mode
  assign w_alarm_set = bus.Alarmset && !bus.Timeset;

  for (genvar k = 0; k < NA; k++) begin : g_slot
    alarm_slot #(
      .NS   (NS),
      .NH   (NH),
      .ND   (ND),
      .RING (RING)
`ifdef MULTI_ALARM_SNOOZE_EN
      ,
      .SNZ  (SNZ)
`endif
    ) u_slot (
      .i_clk     (Pulse),
      .i_rst_n   (Reset),
      .i_set_en  (w_alarm_set && (bus.Sel == SEL_W'(k))),
      .i_min_adv (bus.Minadv),
      .i_hrs_adv (bus.Hrsadv),
      .i_day_adv (bus.Dayadv),
      .i_arm_tog (bus.Armtog && (bus.Sel == SEL_W'(k))),
`ifdef MULTI_ALARM_SNOOZE_EN
      .i_snooze  (bus.Snooze),
`endif
      .i_stop    (bus.Stop),
      .i_timeset (bus.Timeset),
      .i_now     (r_time),
      .o_armed   (w_armed[k]),
      .o_ringing (w_ringing[k]),
      .o_amin    (w_amin[k]),
      .o_ahrs    (w_ahrs[k]),
      .o_aday    (w_aday[k])
    );
  end

`ifndef MULTI_ALARM_SNOOZE_EN
  // Snooze strobe and length have no consumer in this build
  localparam int c_unused_snz = SNZ;
  logic w_unused_snooze;
  assign w_unused_snooze = bus.Snooze;
`endif

  assign bus.TSec    = r_time.sec;
  assign bus.TMin    = r_time.min;
  assign bus.THrs    = r_time.hrs;
  assign bus.TDay    = DAY_W'(r_time.day);
  assign bus.DMin    = w_alarm_set ? w_amin[bus.Sel] : r_time.min;
  assign bus.DHrs    = w_alarm_set ? w_ahrs[bus.Sel] : r_time.hrs;
  assign bus.DDay    = w_alarm_set ? w_aday[bus.Sel] : DDAY_W'(r_time.day);
  assign bus.Armed   = w_armed;
  assign bus.Ringing = w_ringing;
  assign bus.Buzz    = |w_ringing;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_alarm_clock
// Description : Directed self-checking bench for multi_alarm_clock (NA=4,
//               SNZ=1, RING=60). Snooze scenario follows MULTI_ALARM_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_clock;

  logic Pulse = 1'b0;
  logic Reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   t_now    = 0;

  multi_alarm_clock_if #(.NA(4), .ND(7)) bus ();

  multi_alarm_clock #(
    .NS(60), .NH(24), .ND(7), .NA(4), .SNZ(1), .RING(60)
  ) dut (
    .Pulse (Pulse),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Pulse = ~Pulse;

  // Advance n edges, landing 1 time unit after the last rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Pulse);
      #1;
      t_now++;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    t_now = 0;
  endtask

  // Program one alarm's fields from zero, then arm it
  task automatic set_alarm(input int sel, input int mins, input int hrs, input int day);
    bus.Sel      = 2'(sel);
    bus.Alarmset = 1'b1;
    bus.Minadv = 1'b1; step(mins); bus.Minadv = 1'b0;
    bus.Hrsadv = 1'b1; step(hrs);  bus.Hrsadv = 1'b0;
    bus.Dayadv = 1'b1; step(day);  bus.Dayadv = 1'b0;
    bus.Armtog = 1'b1; step(1);    bus.Armtog = 1'b0;
    bus.Alarmset = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (bus.TSec !== 7'd0 || bus.TMin !== 7'd0 || bus.THrs !== 7'd0 || bus.TDay !== 3'd0) begin
      $display("FAIL reset_time: got %0d:%0d:%0d d%0d, need 0:0:0 d0", bus.THrs, bus.TMin, bus.TSec, bus.TDay); failures++; end
    checks++; if (bus.DMin !== 7'd0 || bus.DHrs !== 7'd0 || bus.DDay !== 3'd0) begin
      $display("FAIL reset_display: got %0d %0d %0d, need 0 0 0", bus.DHrs, bus.DMin, bus.DDay); failures++; end
    checks++; if (bus.Armed !== 4'b0 || bus.Ringing !== 4'b0 || bus.Buzz !== 1'b0) begin
      $display("FAIL reset_alarm: armed=%b ringing=%b buzz=%b, need 0", bus.Armed, bus.Ringing, bus.Buzz); failures++; end
    Reset = 1'b1;
    t_now = 0;
  endtask

  task automatic test_rollover();
    do_reset();
    bus.Timeset = 1'b1;
    bus.Hrsadv = 1'b1; step(23); bus.Hrsadv = 1'b0;
    bus.Dayadv = 1'b1; step(6);  bus.Dayadv = 1'b0;
    bus.Minadv = 1'b1; step(60);
    checks++; if (bus.TMin !== 7'd0 || bus.THrs !== 7'd23 || bus.TSec !== 7'd0) begin
      $display("FAIL manual_no_carry: got %0d:%0d:%0d, need 23:0:0", bus.THrs, bus.TMin, bus.TSec); failures++; end
    step(59); bus.Minadv = 1'b0;
    bus.Timeset = 1'b0;
    step(59);
    checks++; if (bus.TSec !== 7'd59 || bus.TMin !== 7'd59 || bus.THrs !== 7'd23 || bus.TDay !== 3'd6) begin
      $display("FAIL preroll: got %0d:%0d:%0d d%0d, need 23:59:59 d6", bus.THrs, bus.TMin, bus.TSec, bus.TDay); failures++; end
    step(1);
    checks++; if (bus.TSec !== 7'd0 || bus.TMin !== 7'd0 || bus.THrs !== 7'd0 || bus.TDay !== 3'd0) begin
      $display("FAIL rollover: got %0d:%0d:%0d d%0d, need 0:0:0 d0", bus.THrs, bus.TMin, bus.TSec, bus.TDay); failures++; end
  endtask

  task automatic test_single_alarm();
    do_reset();
    set_alarm(0, 1, 0, 7);
    bus.Alarmset = 1'b1;
    #1;
    checks++; if (bus.DMin !== 7'd1 || bus.DHrs !== 7'd0 || bus.DDay !== 3'd7) begin
      $display("FAIL alarm_display: got %0d %0d %0d, need 0 1 7", bus.DHrs, bus.DMin, bus.DDay); failures++; end
    bus.Alarmset = 1'b0;
    #1;
    checks++; if (bus.DMin !== 7'd0 || bus.Armed !== 4'b0001) begin
      $display("FAIL time_display: dmin=%0d armed=%b, need 0 0001", bus.DMin, bus.Armed); failures++; end
    step(60 - t_now);
    checks++; if (bus.Buzz !== 1'b0 || bus.TMin !== 7'd1 || bus.TSec !== 7'd0) begin
      $display("FAIL match_edge: buzz=%b min=%0d sec=%0d, need 0 1 0", bus.Buzz, bus.TMin, bus.TSec); failures++; end
    step(1);
    checks++; if (bus.Buzz !== 1'b1 || bus.Ringing !== 4'b0001) begin
      $display("FAIL ring_start: buzz=%b ringing=%b, need 1 0001", bus.Buzz, bus.Ringing); failures++; end
    step(59);
    checks++; if (bus.Buzz !== 1'b1) begin
      $display("FAIL ring_last: buzz=%b, need 1", bus.Buzz); failures++; end
    step(1);
    checks++; if (bus.Buzz !== 1'b0 || bus.Ringing !== 4'b0000) begin
      $display("FAIL auto_silence: buzz=%b ringing=%b, need 0 0000", bus.Buzz, bus.Ringing); failures++; end
  endtask

`ifdef MULTI_ALARM_SNOOZE_EN
  task automatic test_snooze();
    do_reset();
    set_alarm(0, 1, 0, 7);
    step(61 - t_now);
    checks++; if (bus.Buzz !== 1'b1) begin
      $display("FAIL snz_ring: buzz=%b, need 1", bus.Buzz); failures++; end
    step(4);
    bus.Snooze = 1'b1; step(1); bus.Snooze = 1'b0;
    checks++; if (bus.Buzz !== 1'b0) begin
      $display("FAIL snz_enter: buzz=%b, need 0", bus.Buzz); failures++; end
    step(59);
    checks++; if (bus.Buzz !== 1'b0) begin
      $display("FAIL snz_gap: buzz=%b, need 0", bus.Buzz); failures++; end
    step(1);
    checks++; if (bus.Buzz !== 1'b1 || bus.Ringing !== 4'b0001) begin
      $display("FAIL snz_rering: buzz=%b ringing=%b, need 1 0001", bus.Buzz, bus.Ringing); failures++; end
    bus.Stop = 1'b1; step(1); bus.Stop = 1'b0;
    checks++; if (bus.Buzz !== 1'b0) begin
      $display("FAIL snz_stop: buzz=%b, need 0", bus.Buzz); failures++; end
    step(60);
    checks++; if (bus.Buzz !== 1'b0) begin
      $display("FAIL snz_idle: buzz=%b, need 0", bus.Buzz); failures++; end
  endtask
`else
  task automatic test_macro_off();
    do_reset();
    set_alarm(0, 1, 0, 7);
    step(61 - t_now);
    step(4);
    bus.Snooze = 1'b1; step(1); bus.Snooze = 1'b0;
    checks++; if (bus.Buzz !== 1'b1) begin
      $display("FAIL snooze_ignored: buzz=%b, need 1", bus.Buzz); failures++; end
    step(54);
    checks++; if (bus.Buzz !== 1'b1) begin
      $display("FAIL full_ring: buzz=%b, need 1", bus.Buzz); failures++; end
    step(1);
    checks++; if (bus.Buzz !== 1'b0) begin
      $display("FAIL ring_end: buzz=%b, need 0", bus.Buzz); failures++; end
  endtask
`endif

  task automatic test_two_alarms();
    do_reset();
    set_alarm(1, 2, 0, 0);
    set_alarm(3, 2, 0, 0);
    step(120 - t_now);
    checks++; if (bus.Ringing !== 4'b0000 || bus.Armed !== 4'b1010) begin
      $display("FAIL two_pre: ringing=%b armed=%b, need 0000 1010", bus.Ringing, bus.Armed); failures++; end
    step(1);
    checks++; if (bus.Ringing !== 4'b1010 || bus.Buzz !== 1'b1) begin
      $display("FAIL two_ring: ringing=%b buzz=%b, need 1010 1", bus.Ringing, bus.Buzz); failures++; end
    bus.Stop = 1'b1; step(1); bus.Stop = 1'b0;
    checks++; if (bus.Ringing !== 4'b0000 || bus.Buzz !== 1'b0) begin
      $display("FAIL two_stop: ringing=%b buzz=%b, need 0000 0", bus.Ringing, bus.Buzz); failures++; end
  endtask

  task automatic test_day_disarm();
    do_reset();
    set_alarm(2, 1, 0, 2);
    set_alarm(0, 1, 0, 7);
    step(61 - t_now);
    checks++; if (bus.Ringing !== 4'b0001) begin
      $display("FAIL day_mismatch: ringing=%b, need 0001", bus.Ringing); failures++; end
    bus.Sel = 2'd0;
    bus.Armtog = 1'b1; step(1); bus.Armtog = 1'b0;
    checks++; if (bus.Buzz !== 1'b0 || bus.Armed !== 4'b0100) begin
      $display("FAIL disarm: buzz=%b armed=%b, need 0 0100", bus.Buzz, bus.Armed); failures++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_alarm(0, 1, 0, 7);
    step(61 - t_now);
    checks++; if (bus.Buzz !== 1'b1) begin
      $display("FAIL pre_reset_ring: buzz=%b, need 1", bus.Buzz); failures++; end
    Reset = 1'b0;
    #1;
    checks++; if (bus.Buzz !== 1'b0 || bus.Armed !== 4'b0000 || bus.TMin !== 7'd0) begin
      $display("FAIL async_reset: buzz=%b armed=%b min=%0d, need 0 0000 0", bus.Buzz, bus.Armed, bus.TMin); failures++; end
    Reset = 1'b1;
  endtask

  initial begin
    bus.Timeset = 1'b0; bus.Alarmset = 1'b0;
    bus.Minadv = 1'b0;  bus.Hrsadv = 1'b0; bus.Dayadv = 1'b0;
    bus.Sel = 2'd0;     bus.Armtog = 1'b0;
    bus.Snooze = 1'b0;  bus.Stop = 1'b0;
    test_reset();
    test_rollover();
    test_single_alarm();
`ifdef MULTI_ALARM_SNOOZE_EN
    test_snooze();
`else
    test_macro_off();
`endif
    test_two_alarms();
    test_day_disarm();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
